prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 103 ++++++++++
 tb/tb_prog_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream, writes the payload into core
// program memory, then releases the core from reset.
//   clk_i, rst_i        clock, synchronous active-high reset
//   rx_data_i/valid_i   incoming byte stream; rx_ready_o = can accept
//   mem_we_o/addr/wdata byte-write port to program memory (1-cycle latency)
//   core_rstn_o         active-low core reset, released after a good load
//   done_o, err_o       load complete / framing, length or checksum error
// Optional: define PROG_LOADER_CSUM_EN to require a trailing mod-256 checksum.
module prog_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              core_rstn_o,
    output logic              done_o,
    output logic              err_o
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] LEN_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] CSUM   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;
    localparam logic [7:0] SYNC   = 8'hA5;

    logic [2:0]        state;
    logic [15:0]       len;
    logic [ADDR_W-1:0] cnt;
    logic              acc;
    logic [15:0]       n;
    logic              bad_len;
    logic              last;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]        sum;
`endif

    assign rx_ready_o = state != DONE;
    assign done_o     = state == DONE;
    assign err_o      = state == ERR;
    assign acc        = rx_valid_i && rx_ready_o;
    assign n          = {rx_data_i, len[7:0]};
    assign bad_len    = n == 16'd0 || 32'(n) > MEM_BYTES;
    assign last       = 32'(cnt) == 32'(len) - 32'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            len         <= '0;
            cnt         <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            core_rstn_o <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
            sum         <= '0;
`endif
        end else begin
            mem_we_o    <= acc && state == DATA;
            // registered from the state so release trails DONE entry by a cycle
            core_rstn_o <= state == DONE;
            if (acc) begin
                case (state)
                    IDLE, ERR: if (rx_data_i == SYNC) state <= LEN_LO;
                    LEN_LO: begin
                        len[7:0] <= rx_data_i;
                        state    <= LEN_HI;
                    end
                    LEN_HI: begin
                        len[15:8] <= rx_data_i;
                        cnt       <= '0;
`ifdef PROG_LOADER_CSUM_EN
                        sum       <= '0;
`endif
                        state     <= bad_len ? ERR : DATA;
                    end
                    DATA: begin
                        mem_addr_o  <= cnt;
                        mem_wdata_o <= rx_data_i;
                        cnt         <= cnt + 1'b1;
`ifdef PROG_LOADER_CSUM_EN
                        sum         <= sum + rx_data_i;
                        if (last) state <= CSUM;
`else
                        if (last) state <= DONE;
`endif
                    end
`ifdef PROG_LOADER_CSUM_EN
                    CSUM: state <= rx_data_i == sum ? DONE : ERR;
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader.
module tb_prog_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready, mem_we, core_rstn, done, err;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;

    int vecs = 0;
    int errs = 0;
    logic [7:0] tx[$];
    int ea[$], ed[$], wa[$], wd[$];
    logic [7:0] sum;

    prog_loader #(.MEM_BYTES(1024), .ADDR_W(10)) dut (
        .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .core_rstn_o(core_rstn), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we) begin
        wa.push_back(int'(mem_addr));
        wd.push_back(int'(mem_wdata));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        idle(2);
        rst = 1'b0;
        wa.delete(); wd.delete(); ea.delete(); ed.delete(); tx.delete();
        sum = 8'h00;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        idle(1);
        rx_valid = 1'b0;
    endtask

    task automatic flush(input int gap);
        foreach (tx[i]) begin
            send(tx[i]);
            if (gap > 0) idle(gap);
        end
        tx.delete();
    endtask

    task automatic hdr(input int len);
        tx.push_back(8'hA5);
        tx.push_back(8'(len));
        tx.push_back(8'(len >> 8));
        sum = 8'h00;
    endtask

    task automatic pay(input logic [7:0] b);
        tx.push_back(b);
        ea.push_back(ea.size());
        ed.push_back(int'(b));
        sum = sum + b;
    endtask

    task automatic tail();
`ifdef PROG_LOADER_CSUM_EN
        tx.push_back(sum);
`endif
    endtask

    task automatic verify(input string tag);
        idle(2);
        check({tag, "_nwr"}, wa.size(), ea.size());
        for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
            check({tag, "_addr"}, wa[i], ea[i]);
            check({tag, "_data"}, wd[i], ed[i]);
        end
        wa.delete(); wd.delete(); ea.delete(); ed.delete();
    endtask

    initial begin
        do_reset();
        check("rst_ready", rx_ready, 1);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_core", core_rstn, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        // basic 4-byte load and core release timing
        hdr(4); pay(8'h13); pay(8'h00); pay(8'h00); pay(8'h00); tail();
        flush(0);
        check("a_done", done, 1);
        check("a_core_entry", core_rstn, 0);
        idle(1);
        check("a_core_next", core_rstn, 1);
        check("a_we_after", mem_we, 0);
        verify("a");
        send(8'hA5);
        check("a_ready_done", rx_ready, 0);
        idle(2);
        check("a_done_hold", done, 1);
        check("a_no_wr_done", wa.size(), 0);

        // leading junk ignored
        do_reset();
        tx.push_back(8'h00); tx.push_back(8'hFF);
        hdr(2); pay(8'hAA); pay(8'hBB); tail();
        flush(0);
        verify("junk");
        check("junk_done", done, 1);

        // length too large, then recovery
        do_reset();
        hdr(16'h0401);
        flush(0);
        idle(1);
        check("big_err", err, 1);
        check("big_core", core_rstn, 0);
        check("big_ready", rx_ready, 1);
        verify("big");
        hdr(1); pay(8'h55); tail();
        flush(0);
        check("rec_err", err, 0);
        verify("rec");
        check("rec_done", done, 1);

        // zero length
        do_reset();
        hdr(0);
        flush(0);
        check("zero_err", err, 1);
        verify("zero");

`ifdef PROG_LOADER_CSUM_EN
        // bad checksum
        do_reset();
        hdr(2); pay(8'h01); pay(8'h02);
        tx.push_back(8'h04);
        flush(0);
        verify("csum");
        check("csum_err", err, 1);
        check("csum_done", done, 0);
        idle(2);
        check("csum_core", core_rstn, 0);
`endif

        // reset mid-frame with a byte presented on the reset edge
        do_reset();
        hdr(4); pay(8'h11); pay(8'h22);
        flush(0);
        rx_data = 8'h33;
        rx_valid = 1'b1;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rx_valid = 1'b0;
        verify("abort");
        check("abort_core", core_rstn, 0);
        check("abort_done", done, 0);
        send(8'h44);
        hdr(4); pay(8'h01); pay(8'h02); pay(8'h03); pay(8'h04); tail();
        flush(0);
        verify("reload");
        check("reload_done", done, 1);

        // valid toggled every cycle through a 16-byte load
        do_reset();
        hdr(16);
        for (int i = 0; i < 16; i++) pay(8'(i * 7 + 3));
        tail();
        flush(1);
        verify("gap");
        check("gap_done", done, 1);
        check("gap_core", core_rstn, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
